// File: rtl/updown_cmd_scheduler.sv
// updown_cmd_scheduler: turns debounced up/down presses into a buffered stream of count commands
// Ports:
//   i_Clk, i_Rst_L        clock, asynchronous active-low reset
//   i_Up_Sw, i_Dn_Sw      debounced buttons, 0 = pressed
//   o_Cmd_Valid/o_Cmd_Dir command handshake towards the counter (dir 1 = up), i_Cmd_Ready accepts
//   o_Overflow, i_Clr_Ovf sticky dropped-command flag and its synchronous clear
//   o_Rpt_Active          hold-to-repeat engine is repeating
// Build option: define UPDOWN_SCHED_REPEAT_EN to enable the hold-to-repeat engine.
module updown_cmd_scheduler #(
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE  = 2500000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Up_Sw,
  input  logic i_Dn_Sw,
  output logic o_Cmd_Valid,
  output logic o_Cmd_Dir,
  input  logic i_Cmd_Ready,
  output logic o_Overflow,
  input  logic i_Clr_Ovf,
  output logic o_Rpt_Active
);
  localparam int AW = $clog2(FIFO_DEPTH);
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("updown_cmd_scheduler: invalid parameter set");
  end
  logic up_prev_q, up_prev_d, dn_prev_q, dn_prev_d;
  logic pend_up_q, pend_up_d, pend_dn_q, pend_dn_d;
  logic rr_up_q, rr_up_d, ovf_q, ovf_d;
  logic [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d, cnt;
  logic press_up, press_dn, tick_up, tick_dn, ev_up, ev_dn, req_up, req_dn;
  logic win_up, win_any, full, pop, push;
  assign press_up = up_prev_q & ~i_Up_Sw;
  assign press_dn = dn_prev_q & ~i_Dn_Sw;
  assign ev_up    = press_up | tick_up;
  assign ev_dn    = press_dn | tick_dn;
  assign req_up   = ev_up | pend_up_q;
  assign req_dn   = ev_dn | pend_dn_q;
  // up wins when alone or when the round-robin pointer names it
  assign win_up   = req_up & (~req_dn | rr_up_q);
  assign win_any  = req_up | req_dn;
  // pointer distance is the occupancy; the extra MSB distinguishes full from empty
  assign cnt         = wr_q - rd_q;
  assign full        = cnt == (AW+1)'(FIFO_DEPTH);
  assign o_Cmd_Valid = cnt != '0;
  assign o_Cmd_Dir   = o_Cmd_Valid & mem_q[rd_q[AW-1:0]];
  assign pop         = o_Cmd_Valid & i_Cmd_Ready;
  assign push        = win_any & (~full | pop);
  assign o_Overflow  = ovf_q;
  always_comb begin
    up_prev_d = i_Up_Sw;
    dn_prev_d = i_Dn_Sw;
    // a requester that loses arbitration is remembered; winners (granted or dropped) clear
    pend_up_d = req_up & ~win_up;
    pend_dn_d = req_dn & win_up;
    rr_up_d   = (req_up & req_dn) ? ~rr_up_q : rr_up_q;
    ovf_d     = (ev_up & pend_up_q) | (ev_dn & pend_dn_q) | (win_any & ~push) | (ovf_q & ~i_Clr_Ovf);
    mem_d     = mem_q;
    if (push) mem_d[wr_q[AW-1:0]] = win_up;
    wr_d      = wr_q + (AW+1)'(push);
    rd_d      = rd_q + (AW+1)'(pop);
  end
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      up_prev_q <= 1'b1;
      dn_prev_q <= 1'b1;
      pend_up_q <= 1'b0;
      pend_dn_q <= 1'b0;
      rr_up_q   <= 1'b1;
      ovf_q     <= 1'b0;
      mem_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
    end else begin
      up_prev_q <= up_prev_d;
      dn_prev_q <= dn_prev_d;
      pend_up_q <= pend_up_d;
      pend_dn_q <= pend_dn_d;
      rr_up_q   <= rr_up_d;
      ovf_q     <= ovf_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
    end
  end
`ifdef UPDOWN_SCHED_REPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_e;
  localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = RMAX > 1 ? $clog2(RMAX) : 1;
  rpt_state_e state_q, state_d;
  logic owner_up_q, owner_up_d, own_rel, oth_prs;
  logic [TW-1:0] timer_q, timer_d;
  assign own_rel      = owner_up_q ? i_Up_Sw : i_Dn_Sw;
  assign oth_prs      = owner_up_q ? ~i_Dn_Sw : ~i_Up_Sw;
  assign o_Rpt_Active = state_q == REPEAT;
  always_comb begin
    state_d    = state_q;
    owner_up_d = owner_up_q;
    timer_d    = timer_q;
    tick_up    = 1'b0;
    tick_dn    = 1'b0;
    if (state_q == IDLE) begin
      if (press_up & i_Dn_Sw) begin
        state_d    = DELAY;
        owner_up_d = 1'b1;
        timer_d    = '0;
      end else if (press_dn & i_Up_Sw) begin
        state_d    = DELAY;
        owner_up_d = 1'b0;
        timer_d    = '0;
      end
    end else if (own_rel | oth_prs) begin
      state_d = IDLE;
      timer_d = '0;
    end else if (timer_q == (state_q == DELAY ? TW'(REPEAT_DELAY - 1) : TW'(REPEAT_RATE - 1))) begin
      tick_up = owner_up_q;
      tick_dn = ~owner_up_q;
      state_d = REPEAT;
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= IDLE;
      owner_up_q <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_up_q <= owner_up_d;
      timer_q    <= timer_d;
    end
  end
`else
  assign tick_up      = 1'b0;
  assign tick_dn      = 1'b0;
  assign o_Rpt_Active = 1'b0;
`endif
endmodule

// File: tb/tb_updown_cmd_scheduler.sv
// tb_updown_cmd_scheduler: directed and random checks of updown_cmd_scheduler against a queue-based reference model
module tb_updown_cmd_scheduler;
  localparam int DEPTH = 4;
  localparam int RD    = 8;
  localparam int RR    = 4;
  logic clk = 1'b0, rst_n = 1'b0, up = 1'b1, dn = 1'b1, rdy = 1'b0, clr = 1'b0;
  logic cmd_valid, cmd_dir, ovf, rpt;
  int n_tests = 0, n_fail = 0;
  bit mq[$];
  bit beats[$];
  bit m_up_prev, m_dn_prev, m_pu, m_pd, m_rr, m_ovf;
  int m_mode, m_own, m_cnt;
  int rpt_mid, ones;
  bit ru, rdn;
  updown_cmd_scheduler #(.FIFO_DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Up_Sw(up), .i_Dn_Sw(dn),
    .o_Cmd_Valid(cmd_valid), .o_Cmd_Dir(cmd_dir), .i_Cmd_Ready(rdy),
    .o_Overflow(ovf), .i_Clr_Ovf(clr), .o_Rpt_Active(rpt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int beat(input int i);
    return beats.size() > i ? int'(beats[i]) : 9;
  endfunction
  function automatic int beat_ones();
    int s = 0;
    foreach (beats[i]) s += beats[i];
    return s;
  endfunction
  task automatic model_reset();
    mq.delete();
    m_up_prev = 1; m_dn_prev = 1; m_pu = 0; m_pd = 0; m_rr = 1; m_ovf = 0;
    m_mode = 0; m_own = 0; m_cnt = 0;
  endtask
  // one clock of the reference: fairness, pending memory, bounded FIFO, sticky overflow, hold-to-repeat
  task automatic model_step();
    bit pu, pd, tu, td, eu, ed, qu, qd, w, set, full, pop, held, other;
    pu = m_up_prev && !up;
    pd = m_dn_prev && !dn;
    tu = 0; td = 0;
`ifdef UPDOWN_SCHED_REPEAT_EN
    if (m_mode != 0) begin
      held  = m_own ? !up : !dn;
      other = m_own ? !dn : !up;
      if (!held || other) m_mode = 0;
      else begin
        m_cnt++;
        if (m_cnt == (m_mode == 1 ? RD : RR)) begin
          if (m_own != 0) tu = 1; else td = 1;
          m_mode = 2;
          m_cnt = 0;
        end
      end
    end else if (pu && dn) begin
      m_mode = 1; m_own = 1; m_cnt = 0;
    end else if (pd && up) begin
      m_mode = 1; m_own = 0; m_cnt = 0;
    end
`else
    held = 0; other = 0;
`endif
    eu = pu || tu;
    ed = pd || td;
    set = (eu && m_pu) || (ed && m_pd);
    qu = eu || m_pu;
    qd = ed || m_pd;
    if (qu && qd) begin
      w = m_rr;
      m_rr = !m_rr;
      m_pu = !w;
      m_pd = w;
    end else begin
      w = qu;
      m_pu = 0;
      m_pd = 0;
    end
    full = mq.size() == DEPTH;
    pop = mq.size() > 0 && rdy;
    if (pop) void'(mq.pop_front());
    if (qu || qd) begin
      if (!full || pop) mq.push_back(w);
      else set = 1;
    end
    m_ovf = set || (m_ovf && !clr);
    m_up_prev = up;
    m_dn_prev = dn;
  endtask
  task automatic step(input bit u, input bit d, input bit r, input bit c);
    int exp_dir;
    up = u; dn = d; rdy = r; clr = c;
    @(negedge clk);
    if (cmd_valid && rdy) beats.push_back(cmd_dir);
    model_step();
    @(posedge clk);
    #1;
    exp_dir = mq.size() > 0 ? int'(mq[0]) : 0;
    chk("valid", cmd_valid, mq.size() > 0);
    chk("dir", cmd_dir, exp_dir);
    chk("ovf", ovf, m_ovf);
    chk("rpt", rpt, m_mode == 2);
  endtask
  task automatic do_reset();
    rst_n = 0;
    up = 1; dn = 1; rdy = 1; clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_dir", cmd_dir, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_rpt", rpt, 0);
    rst_n = 1;
  endtask
  initial begin
    do_reset();
    beats.delete();
    repeat (10) step(0, 1, 1, 0);
    repeat (3) step(1, 1, 1, 0);
    chk("t1_beats", beats.size(), 1);
    chk("t1_dir", beat(0), 1);
    beats.delete();
    step(0, 0, 1, 0);
    repeat (3) step(1, 1, 1, 0);
    chk("t2a_beats", beats.size(), 2);
    chk("t2a_first", beat(0), 1);
    chk("t2a_second", beat(1), 0);
    beats.delete();
    step(0, 0, 1, 0);
    repeat (3) step(1, 1, 1, 0);
    chk("t2b_beats", beats.size(), 2);
    chk("t2b_first", beat(0), 0);
    chk("t2b_second", beat(1), 1);
    beats.delete();
    repeat (5) begin
      step(0, 1, 0, 0);
      step(1, 1, 0, 0);
    end
    chk("t3_valid", cmd_valid, 1);
    chk("t3_ovf", ovf, 1);
    step(1, 1, 0, 1);
    chk("t3_clr", ovf, 0);
    repeat (6) step(1, 1, 1, 0);
    chk("t3_drain", beats.size(), 4);
    chk("t3_ups", beat_ones(), 4);
    beats.delete();
    rpt_mid = 0;
    for (int i = 0; i < 30; i++) begin
      step(1, 0, 1, 0);
      if (i == 15) rpt_mid = rpt;
    end
    repeat (4) step(1, 1, 1, 0);
`ifdef UPDOWN_SCHED_REPEAT_EN
    chk("t4_beats", beats.size(), 7);
    chk("t4_rpt_mid", rpt_mid, 1);
`else
    chk("t5_beats", beats.size(), 1);
    chk("t5_rpt_mid", rpt_mid, 0);
`endif
    chk("t4_downs", beat_ones(), 0);
    repeat (12) step(1, 0, 1, 0);
    repeat (20) step(0, 0, 1, 0);
    chk("t4_stop_rpt", rpt, 0);
    repeat (4) step(1, 1, 1, 0);
    repeat (5) begin
      step(0, 1, 0, 0);
      step(1, 1, 0, 0);
    end
    step(1, 1, 1, 0);
    #3;
    rst_n = 0;
    #1;
    chk("t6_async_valid", cmd_valid, 0);
    chk("t6_async_ovf", ovf, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    beats.delete();
    repeat (8) step(1, 1, 1, 0);
    chk("t6_no_cmd", beats.size(), 0);
    ru = 1; rdn = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) ru = !ru;
      if ($urandom_range(0, 5) == 0) rdn = !rdn;
      step(ru, rdn, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
